// File: rtl/ultrasonic_sequencer.sv
// rtl/ultrasonic_sequencer.sv - HC-SR04 style trigger/echo measurement sequencer
module ultrasonic_sequencer #(
    parameter int TRIG_CYCLES   = 500,
    parameter int CYC_PER_CM    = 2900,
    parameter int ECHO_TIMEOUT  = 1_000_000,
    parameter int PERIOD_CYCLES = 3_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        start,
    input  logic        echo,
    output logic        trig,
    output logic        busy,
    output logic        dist_valid,
    output logic [19:0] echo_cycles,
    output logic [8:0]  dist_cm,
    output logic        timeout
);

    localparam int TW = $clog2(TRIG_CYCLES + 1);
    localparam int PW = $clog2(PERIOD_CYCLES + 1);
    localparam int CW = (CYC_PER_CM > 1) ? $clog2(CYC_PER_CM) : 1;

    localparam logic [TW-1:0] TRIG_LAST    = TW'(TRIG_CYCLES);
    localparam logic [PW-1:0] PERIOD_END   = PW'(PERIOD_CYCLES);
    localparam logic [19:0]   TIMEOUT_VAL  = 20'(ECHO_TIMEOUT);
    localparam logic [19:0]   TIMEOUT_LAST = 20'(ECHO_TIMEOUT - 1);
    localparam logic [CW-1:0] PRE_LAST     = CW'(CYC_PER_CM - 1);
    // The cycle that detects the rise is itself an echo-high cycle, so the
    // prescaler and cm count are preloaded as if one cycle was already counted.
    localparam logic [CW-1:0] PRE_FIRST    = (CYC_PER_CM > 1) ? CW'(1) : CW'(0);
    localparam logic [8:0]    CM_FIRST     = (CYC_PER_CM > 1) ? 9'd0 : 9'd1;
    localparam logic [8:0]    CM_MAX       = 9'd511;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        HOLDOFF
    } state_t;

    state_t          state;
    logic            echo_m;
    logic            echo_s;
    logic [TW-1:0]   trig_cnt;
    logic [PW-1:0]   period_cnt;
    logic [19:0]     meas_cnt;
    logic [CW-1:0]   pre_cnt;
    logic [8:0]      cm_int;

    // Two-flop synchronizer for the asynchronous sensor echo
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            echo_m <= 1'b0;
            echo_s <= 1'b0;
        end else begin
            echo_m <= echo;
            echo_s <= echo_m;
        end
    end

    // Measurement sequencer: trigger, wait for echo, time it, latch result, hold off
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            trig        <= 1'b0;
            busy        <= 1'b0;
            dist_valid  <= 1'b0;
            echo_cycles <= '0;
            dist_cm     <= '0;
            timeout     <= 1'b0;
            trig_cnt    <= '0;
            period_cnt  <= '0;
            meas_cnt    <= '0;
            pre_cnt     <= '0;
            cm_int      <= '0;
        end else begin
            dist_valid <= 1'b0;
            // Period counter holds 1 on the trig rising edge, so its value
            // equals the number of edges elapsed since that rise.
            if (period_cnt != PERIOD_END) begin
                period_cnt <= period_cnt + PW'(1);
            end

            case (state)
                IDLE: begin
                    trig_cnt   <= '0;
                    period_cnt <= '0;
                    meas_cnt   <= '0;
                    pre_cnt    <= '0;
                    cm_int     <= '0;
                    if (enable || start) begin
                        state      <= TRIG;
                        trig       <= 1'b1;
                        busy       <= 1'b1;
                        trig_cnt   <= TW'(1);
                        period_cnt <= PW'(1);
                    end
                end

                TRIG: begin
                    if (trig_cnt == TRIG_LAST) begin
                        trig     <= 1'b0;
                        state    <= WAIT_RISE;
                        meas_cnt <= '0;
                    end else begin
                        trig_cnt <= trig_cnt + TW'(1);
                    end
                end

                WAIT_RISE: begin
                    if (echo_s) begin
                        state    <= MEASURE;
                        meas_cnt <= 20'd1;
                        pre_cnt  <= PRE_FIRST;
                        cm_int   <= CM_FIRST;
                    end else if (meas_cnt == TIMEOUT_LAST) begin
                        echo_cycles <= TIMEOUT_VAL;
                        dist_cm     <= CM_MAX;
                        timeout     <= 1'b1;
                        dist_valid  <= 1'b1;
                        state       <= HOLDOFF;
                    end else begin
                        meas_cnt <= meas_cnt + 20'd1;
                    end
                end

                MEASURE: begin
                    if (!echo_s) begin
                        echo_cycles <= meas_cnt;
                        dist_cm     <= cm_int;
                        timeout     <= 1'b0;
                        dist_valid  <= 1'b1;
                        state       <= HOLDOFF;
                    end else if (meas_cnt == TIMEOUT_LAST) begin
                        echo_cycles <= TIMEOUT_VAL;
                        dist_cm     <= CM_MAX;
                        timeout     <= 1'b1;
                        dist_valid  <= 1'b1;
                        state       <= HOLDOFF;
                    end else begin
                        meas_cnt <= meas_cnt + 20'd1;
                        if (pre_cnt == PRE_LAST) begin
                            pre_cnt <= '0;
                            if (cm_int != CM_MAX) begin
                                cm_int <= cm_int + 9'd1;
                            end
                        end else begin
                            pre_cnt <= pre_cnt + CW'(1);
                        end
                    end
                end

                HOLDOFF: begin
                    // A stuck echo must clear before the sensor is retriggered
                    if ((period_cnt == PERIOD_END) && !echo_s) begin
                        if (enable) begin
                            state      <= TRIG;
                            trig       <= 1'b1;
                            trig_cnt   <= TW'(1);
                            period_cnt <= PW'(1);
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    trig  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/ultrasonic_sequencer.md
# ultrasonic_sequencer

Measurement controller for the HC-SR04-style ultrasonic ranging path. It issues the 10 µs trigger pulse, waits for and times the echo pulse, and converts the width to centimetres with a prescaled counter. It enforces a minimum repetition period and an echo timeout, then presents each result with a one-cycle valid strobe. The LED/display logic and any later filtering consume its outputs; it replaces free-running trigger and echo counters with one sequenced measurement cycle.

## Interface
- TRIG_CYCLES, 500: trig high time in clk cycles (10 µs at 50 MHz).
- CYC_PER_CM, 2900: clk cycles of echo width per cm (58 µs/cm at 50 MHz).
- ECHO_TIMEOUT, 1_000_000: maximum cycles spent waiting for echo rise, and maximum echo width (20 ms).
- PERIOD_CYCLES, 3_000_000: minimum cycles between successive trig rising edges (60 ms).
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  level; while 1, measurements repeat back-to-back at PERIOD_CYCLES spacing.
- start  input  1  single-measurement request, sampled only in IDLE.
- echo  input  1  raw sensor echo, asynchronous; passes through a 2-flop synchronizer (echo_s).
- trig  output  1  sensor trigger, registered.
- busy  output  1  high in every state except IDLE.
- dist_valid  output  1  one-cycle strobe: result outputs updated this cycle.
- echo_cycles  output  20  measured echo width in clk cycles.
- dist_cm  output  9  floor(echo_cycles / CYC_PER_CM).
- timeout  output  1  qualifies the latest result: 1 = no echo or echo overlong.

## Operation
- States: IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF.
- IDLE: if enable or start is 1, go to TRIG. Clear the period counter and the measurement counters.
- TRIG: trig = 1 for exactly TRIG_CYCLES cycles, then go to WAIT_RISE.
- WAIT_RISE: count cycles. If echo_s = 1, go to MEASURE. If the count reaches ECHO_TIMEOUT, finish with timeout = 1.
- MEASURE: each cycle echo_s = 1, increment echo_cycles_int. A prescaler counts 0..CYC_PER_CM-1; on each wrap, increment cm_int, saturating at 511. When echo_s = 0, finish normally. If echo_cycles_int reaches ECHO_TIMEOUT, finish with timeout = 1.
- Finish (normal): latch echo_cycles ← echo_cycles_int and dist_cm ← cm_int, set timeout ← 0, pulse dist_valid, go to HOLDOFF.
- Finish (timeout): set echo_cycles ← ECHO_TIMEOUT, dist_cm ← 511, timeout ← 1, pulse dist_valid, go to HOLDOFF.
- HOLDOFF: wait until both conditions hold: the period counter (started at the trig rising edge) reaches PERIOD_CYCLES, and echo_s = 0. Then go to TRIG if enable = 1, else go to IDLE.
- start while busy: ignored, not queued.
- enable dropped mid-cycle: the current measurement completes normally, then the FSM returns to IDLE.
- Echo already high when WAIT_RISE is entered: counts as the rise. The measurement starts the next cycle.
- Result outputs hold their values between dist_valid strobes.

## Timing
- Reset (async, immediate): state = IDLE. trig, busy, dist_valid, timeout = 0. echo_cycles = 0, dist_cm = 0. Synchronizer flops = 0.
- start or enable sampled high in IDLE: trig = 1 from the next edge.
- trig high exactly TRIG_CYCLES cycles.
- Raw echo to echo_s: 2 cycles. Both edges are delayed equally, so echo_cycles = raw high width ±1 cycle.
- dist_valid rises on the edge that leaves MEASURE/WAIT_RISE: at most 3 cycles after the raw echo falls. It is high for exactly 1 cycle.
- Trig-rise to trig-rise spacing: exactly PERIOD_CYCLES in continuous mode when echo is short. It is longer only if echo_s is still high at the period end.
- rst asserted mid-operation: trig drops asynchronously. No dist_valid is produced for the aborted measurement.

## Test plan
Bench parameters: TRIG_CYCLES=5, CYC_PER_CM=10, ECHO_TIMEOUT=200, PERIOD_CYCLES=400.
- Reset then idle: rst pulse, enable=0, start=0 for 50 cycles -> all outputs 0, busy 0, trig never high.
- Single shot: start 1 cycle; echo rises 20 cycles after trig falls and stays high 57 cycles -> trig high 5 cycles; one dist_valid; echo_cycles=57 (±1); dist_cm=5; timeout=0; busy falls 400 cycles after trig rise.
- No echo: start, echo held 0 -> dist_valid exactly 200 cycles after entering WAIT_RISE; timeout=1; echo_cycles=200; dist_cm=511.
- Overlong / stuck echo: echo high for 500 cycles -> dist_valid with timeout=1 after 200 counted cycles. Next trig waits until echo_s falls, even though the period has elapsed.
- Continuous: enable=1, echo 30 cycles wide each time -> trig rises every 400 cycles; dist_cm=3 each strobe. A start pulse while busy causes no extra trig. enable=0 mid-MEASURE -> that result still strobes, then IDLE.
- Async reset mid-TRIG and mid-MEASURE -> trig=0 immediately, no dist_valid. Previous result outputs cleared to 0; next start behaves as in the single-shot case.
